// File: rtl/fetch_ctrl_pkg.sv
// fetch_pkg: shared state encoding and default sizes for fetch_ctrl.
package fetch_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_INST_W = 32;
  localparam int DEF_RESET_PC = 0;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, STEP_WAIT} state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: program memory read bus between fetch_ctrl (master) and the memory (slave).
interface fetch_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 32
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [INST_W-1:0] rdata;
  modport master (output en, addr, input rdata);
  modport slave (input en, addr, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns PC and IR, sequences program memory reads and holds each instruction until executed.
// Optional SINGLE_STEP_EN adds step_mode/step ports and a STEP_WAIT state between instructions.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INST_W   = DEF_INST_W,
  parameter int MEM_LAT  = 1,
  parameter int RESET_PC = DEF_RESET_PC
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  fetch_ctrl_if.master      imem,
  output logic [INST_W-1:0] o_ir,
  output logic              o_ir_valid,
  input  logic              i_exec_done,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_halt_req,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  output logic              o_pc_wrapped
`ifdef SINGLE_STEP_EN
  ,
  input  logic              i_step_mode,
  input  logic              i_step
`endif
);
  localparam logic [ADDR_W-1:0] W_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [2:0]        W_LAT      = 3'(MEM_LAT);
  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_pc, w_pc;
  logic [INST_W-1:0]   r_ir, w_ir;
  logic                r_ir_valid, w_ir_valid;
  logic [2:0]          r_cnt, w_cnt;
  logic                r_wrapped, w_wrapped;
  logic                w_after_exec;
`ifdef SINGLE_STEP_EN
  assign w_after_exec = i_step_mode;
`else
  assign w_after_exec = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= W_RESET_PC;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_cnt      <= '0;
      r_wrapped  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_ir       <= w_ir;
      r_ir_valid <= w_ir_valid;
      r_cnt      <= w_cnt;
      r_wrapped  <= w_wrapped;
    end
  end
  // Read data is taken on the MEM_LAT-th cycle after the single enable pulse.
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_ir       = r_ir;
    w_ir_valid = r_ir_valid;
    w_cnt      = r_cnt;
    w_wrapped  = r_wrapped;
    imem.en    = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        w_state = FETCH;
        w_cnt   = '0;
      end
      FETCH: begin
        imem.en = (r_cnt == 3'd0);
        w_cnt   = (r_cnt == W_LAT) ? 3'd0 : r_cnt + 3'd1;
        if (r_cnt == W_LAT) begin
          w_ir       = imem.rdata;
          w_ir_valid = 1'b1;
          w_state    = EXEC;
        end
      end
      EXEC: if (i_exec_done) begin
        w_ir_valid = 1'b0;
        w_state    = i_halt_req ? HALT : (w_after_exec ? STEP_WAIT : FETCH);
        if (!i_halt_req) begin
          w_pc      = i_branch_taken ? i_branch_target : r_pc + ADDR_W'(1);
          w_wrapped = r_wrapped | (!i_branch_taken && (&r_pc));
        end
      end
`ifdef SINGLE_STEP_EN
      STEP_WAIT: if (i_step) begin
        w_state = FETCH;
        w_cnt   = '0;
      end
`endif
      default: ;
    endcase
  end
  assign imem.addr    = r_pc;
  assign o_ir         = r_ir;
  assign o_ir_valid   = r_ir_valid;
  assign o_pc         = r_pc;
  assign o_halted     = (r_state == HALT);
  assign o_pc_wrapped = r_wrapped;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl with a 1-cycle synchronous program memory model.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [4:0]  branch_target = '0;
  logic        halt_req = 1'b0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [4:0]  pc;
  logic        halted;
  logic        pc_wrapped;
  logic [31:0] mem [32];
  int          vectors = 0;
  int          miscompares = 0;
`ifdef SINGLE_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
`endif
  fetch_ctrl_if #(.ADDR_W(5), .INST_W(32)) bus ();
  fetch_ctrl #(.ADDR_W(5), .INST_W(32), .MEM_LAT(1), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .i_start(start), .imem(bus),
    .o_ir(ir), .o_ir_valid(ir_valid), .i_exec_done(exec_done),
    .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_halt_req(halt_req), .o_pc(pc), .o_halted(halted), .o_pc_wrapped(pc_wrapped)
`ifdef SINGLE_STEP_EN
    , .i_step_mode(step_mode), .i_step(step)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.en) bus.rdata <= mem[bus.addr];
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL reset_pc got %0d exp 0", pc); end
    vectors++; if (ir !== 32'd0) begin miscompares++; $display("FAIL reset_ir got %h exp 0", ir); end
    vectors++; if ({ir_valid, bus.en, halted, pc_wrapped} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {ir_valid, bus.en, halted, pc_wrapped}); end
    vectors++; if (bus.addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %0d exp 0", bus.addr); end
  endtask
  task automatic test_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if ({bus.en, bus.addr} !== {1'b1, 5'd0}) begin miscompares++; $display("FAIL start_en got en=%b addr=%0d exp en=1 addr=0", bus.en, bus.addr); end
    tick();
    vectors++; if ({bus.en, ir_valid} !== 2'b00) begin miscompares++; $display("FAIL start_wait got en=%b v=%b exp 00", bus.en, ir_valid); end
    tick();
    vectors++; if ({ir_valid, ir, pc} !== {1'b1, 32'hA5A5_0001, 5'd0}) begin miscompares++; $display("FAIL start_ir got v=%b ir=%h pc=%0d exp v=1 ir=a5a50001 pc=0", ir_valid, ir, pc); end
  endtask
  task automatic test_sequential;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++; if ({ir_valid, ir} !== {1'b1, mem[k-1]}) begin miscompares++; $display("FAIL seq_hold%0d got v=%b ir=%h exp v=1 ir=%h", k, ir_valid, ir, mem[k-1]); end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      vectors++; if ({ir_valid, pc} !== {1'b0, 5'(k)}) begin miscompares++; $display("FAIL seq_pc%0d got v=%b pc=%0d exp v=0 pc=%0d", k, ir_valid, pc, k); end
      tick();
      vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL seq_early%0d got v=%b exp 0", k, ir_valid); end
      tick();
      vectors++; if ({ir_valid, ir} !== {1'b1, mem[k]}) begin miscompares++; $display("FAIL seq_ir%0d got v=%b ir=%h exp v=1 ir=%h", k, ir_valid, ir, mem[k]); end
    end
  endtask
  task automatic test_branch;
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 5'd20;
    tick();
    exec_done = 1'b0; branch_taken = 1'b0;
    vectors++; if ({pc, bus.addr, bus.en} !== {5'd20, 5'd20, 1'b1}) begin miscompares++; $display("FAIL branch_addr got pc=%0d addr=%0d en=%b exp 20 20 1", pc, bus.addr, bus.en); end
    tick(2);
    vectors++; if ({ir_valid, ir, pc_wrapped} !== {1'b1, mem[20], 1'b0}) begin miscompares++; $display("FAIL branch_ir got v=%b ir=%h w=%b exp v=1 ir=%h w=0", ir_valid, ir, pc_wrapped, mem[20]); end
  endtask
  task automatic test_wrap;
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 5'd31;
    tick();
    exec_done = 1'b0; branch_taken = 1'b0;
    tick(2);
    vectors++; if ({pc, ir} !== {5'd31, mem[31]}) begin miscompares++; $display("FAIL wrap_pre got pc=%0d ir=%h exp 31 %h", pc, ir, mem[31]); end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    vectors++; if ({pc, pc_wrapped} !== {5'd0, 1'b1}) begin miscompares++; $display("FAIL wrap_pc got pc=%0d w=%b exp 0 1", pc, pc_wrapped); end
    tick(2);
    vectors++; if ({ir_valid, ir} !== {1'b1, mem[0]}) begin miscompares++; $display("FAIL wrap_ir got v=%b ir=%h exp 1 %h", ir_valid, ir, mem[0]); end
    branch_taken = 1'b1; branch_target = 5'd7; halt_req = 1'b1;
    tick();
    branch_taken = 1'b0; halt_req = 1'b0;
    vectors++; if ({pc, ir_valid, halted} !== {5'd0, 1'b1, 1'b0}) begin miscompares++; $display("FAIL no_done got pc=%0d v=%b h=%b exp 0 1 0", pc, ir_valid, halted); end
  endtask
  task automatic test_halt;
    exec_done = 1'b1; halt_req = 1'b1; branch_taken = 1'b1; branch_target = 5'd9;
    tick();
    exec_done = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    vectors++; if ({halted, pc, ir_valid, bus.en} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL halt got h=%b pc=%0d v=%b en=%b exp 1 0 0 0", halted, pc, ir_valid, bus.en); end
    start = 1'b1; exec_done = 1'b1;
    tick(3);
    start = 1'b0; exec_done = 1'b0;
    vectors++; if ({halted, pc, ir_valid, bus.en, pc_wrapped} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL halt_stay got h=%b pc=%0d v=%b en=%b w=%b exp 1 0 0 0 1", halted, pc, ir_valid, bus.en, pc_wrapped); end
  endtask
  task automatic test_reset_fetch;
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (bus.en !== 1'b1) begin miscompares++; $display("FAIL rf_fetch got en=%b exp 1", bus.en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if ({pc, ir, ir_valid, bus.en, halted, pc_wrapped} !== {5'd0, 32'd0, 4'b0000}) begin miscompares++; $display("FAIL rf_reset got pc=%0d ir=%h v=%b en=%b h=%b w=%b exp all 0", pc, ir, ir_valid, bus.en, halted, pc_wrapped); end
    tick(3);
    vectors++; if ({ir_valid, bus.en, ir} !== {2'b00, 32'd0}) begin miscompares++; $display("FAIL rf_idle got v=%b en=%b ir=%h exp 0 0 0", ir_valid, bus.en, ir); end
  endtask
`ifdef SINGLE_STEP_EN
  task automatic test_step;
    int fetched;
    step_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    vectors++; if ({pc, ir_valid} !== {5'd1, 1'b0}) begin miscompares++; $display("FAIL step_pc got pc=%0d v=%b exp 1 0", pc, ir_valid); end
    fetched = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.en || ir_valid) fetched++;
      tick();
    end
    vectors++; if (fetched !== 0) begin miscompares++; $display("FAIL step_wait got %0d active cycles exp 0", fetched); end
    step = 1'b1;
    tick();
    step = 1'b0;
    vectors++; if (bus.en !== 1'b1) begin miscompares++; $display("FAIL step_fetch got en=%b exp 1", bus.en); end
    tick();
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL step_early got v=%b exp 0", ir_valid); end
    tick();
    vectors++; if ({ir_valid, ir} !== {1'b1, mem[1]}) begin miscompares++; $display("FAIL step_ir got v=%b ir=%h exp 1 %h", ir_valid, ir, mem[1]); end
    step_mode = 1'b0;
  endtask
`endif
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    mem[0] = 32'hA5A5_0001;
    #2;
    test_reset();
    test_start();
    test_sequential();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_fetch();
`ifdef SINGLE_STEP_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
